vending_ctrl_param: RTL and testbench

Parametrised successor to the single-product-set burrito vending FSM. It supports NUM_ITEMS products with per-item prices, and coins are edge-detected internally. Overpayment is protected and a vend uses a ready/valid handshake to the dispenser. Change is returned greedily one coin per cycle. It sits between the board button/switch debouncers and the dispenser/display logic; the 7-segment decode lives outside.

---
 rtl/vending_pkg.sv | 51 +++++
 rtl/vending_change_gen.sv | 18 +
 rtl/vending_ctrl_param.sv | 228 ++++++++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types, coin constants and coin helper functions for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam int unsigned COIN_W    = 3;
  localparam int unsigned NICKEL_C  = 5;
  localparam int unsigned DIME_C    = 10;
  localparam int unsigned QUARTER_C = 25;

  localparam int unsigned IDX_NICKEL  = 0;
  localparam int unsigned IDX_DIME    = 1;
  localparam int unsigned IDX_QUARTER = 2;

  localparam logic [COIN_W-1:0] COIN_NONE    = 3'b000;
  localparam logic [COIN_W-1:0] COIN_NICKEL  = 3'b001;
  localparam logic [COIN_W-1:0] COIN_DIME    = 3'b010;
  localparam logic [COIN_W-1:0] COIN_QUARTER = 3'b100;

  // Largest coin not exceeding the balance; none when the balance is below a nickel.
  function automatic logic [COIN_W-1:0] greedy_coin(input logic [31:0] bal);
    if (bal >= QUARTER_C)     return COIN_QUARTER;
    else if (bal >= DIME_C)   return COIN_DIME;
    else if (bal >= NICKEL_C) return COIN_NICKEL;
    else                      return COIN_NONE;
  endfunction

  // Highest-value coin among simultaneous insertion events.
  function automatic logic [COIN_W-1:0] coin_priority(input logic [COIN_W-1:0] evt);
    if (evt[IDX_QUARTER])     return COIN_QUARTER;
    else if (evt[IDX_DIME])   return COIN_DIME;
    else if (evt[IDX_NICKEL]) return COIN_NICKEL;
    else                      return COIN_NONE;
  endfunction

  // Cent value of a one-hot coin.
  function automatic logic [31:0] coin_value(input logic [COIN_W-1:0] oh);
    case (oh)
      COIN_QUARTER: return 32'(QUARTER_C);
      COIN_DIME:    return 32'(DIME_C);
      COIN_NICKEL:  return 32'(NICKEL_C);
      default:      return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_change_gen.sv
// Greedy change step: picks the largest coin that fits the balance and its value.
module vending_change_gen
  import vending_pkg::*;
#(
  parameter int unsigned BAL_W = 8
) (
  input  logic [BAL_W-1:0]  balance_i,
  output logic [COIN_W-1:0] coin_o,
  output logic [BAL_W-1:0]  value_o
);

  // Pure combinational coin selection.
  always_comb begin
    coin_o  = greedy_coin(32'(balance_i));
    value_o = BAL_W'(coin_value(coin_o));
  end

endmodule

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: multi-item pricing, coin edge detection,
// overpayment guard, ready/valid vend handshake and greedy change return.
// Optional macro TIMEOUT_EN adds an inactivity auto-refund in IDLE.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int unsigned                 NUM_ITEMS   = 3,
  parameter int unsigned                 BAL_W       = 8,
  parameter int unsigned                 MAX_BAL     = 200,
  parameter logic [NUM_ITEMS*BAL_W-1:0]  PRICES      = {8'd70, 8'd50, 8'd15},
  parameter int unsigned                 ERR_CYCLES  = 4,
  parameter int unsigned                 TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    coin_in,
  input  logic [NUM_ITEMS-1:0]          sel,
  input  logic                          cancel,
  output logic                          vend_valid,
  output logic [$clog2(NUM_ITEMS)-1:0]  vend_item,
  input  logic                          vend_ready,
  output logic [2:0]                    change_coin,
  output logic                          coin_reject,
  output logic                          err,
  output logic [BAL_W-1:0]              balance
);

  localparam int unsigned IDX_W = $clog2(NUM_ITEMS);
  localparam int unsigned SUM_W = BAL_W + 1;
  localparam int unsigned ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [BAL_W-1:0]    balance_q, balance_d;
  logic                vend_valid_q, vend_valid_d;
  logic [IDX_W-1:0]    vend_item_q, vend_item_d;
  logic [COIN_W-1:0]   change_coin_q, change_coin_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                sel_armed_q, sel_armed_d;
  logic [COIN_W-1:0]   coin_hist_q;

  logic [COIN_W-1:0]   coin_evt, coin_top;
  logic                coin_any, coin_multi, coin_fits;
  logic [BAL_W-1:0]    coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [BAL_W-1:0]    sel_price, vend_price, vend_rem;
  logic [COIN_W-1:0]   gen_coin;
  logic [BAL_W-1:0]    gen_value, change_rem;

`ifdef TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                activity;
`else
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  vending_change_gen #(.BAL_W(BAL_W)) u_change_gen (
    .balance_i (balance_q),
    .coin_o    (gen_coin),
    .value_o   (gen_value)
  );

  // Coin edge detection, priority pick and overflow check.
  always_comb begin
    coin_evt   = coin_in & ~coin_hist_q;
    coin_any   = |coin_evt;
    coin_top   = coin_priority(coin_evt);
    coin_multi = (coin_evt != coin_top);
    coin_val   = BAL_W'(coin_value(coin_top));
    coin_sum   = SUM_W'(balance_q) + SUM_W'(coin_val);
    coin_fits  = (coin_sum <= SUM_W'(MAX_BAL));
  end

  // Lowest-index selected item and price lookups for selection and vend.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_price  = '0;
    vend_price = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      if (sel[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_price = PRICES[i*BAL_W +: BAL_W];
      end
      if (vend_item_q == IDX_W'(i)) begin
        vend_price = PRICES[i*BAL_W +: BAL_W];
      end
    end
    vend_rem   = balance_q - vend_price;
    change_rem = balance_q - gen_value;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    balance_d     = balance_q;
    vend_valid_d  = 1'b0;
    vend_item_d   = vend_item_q;
    change_coin_d = COIN_NONE;
    coin_reject_d = 1'b0;
    err_d         = 1'b0;
    err_cnt_d     = err_cnt_q;
    sel_armed_d   = (sel == '0) ? 1'b1 : sel_armed_q;
`ifdef TIMEOUT_EN
    to_cnt_d      = '0;
    activity      = coin_any | (|sel) | cancel;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cancel && (balance_q != '0)) begin
          state_d       = ST_CHANGE;
          coin_reject_d = coin_any;
        end else if (sel_found && sel_armed_q) begin
          coin_reject_d = coin_any;
          sel_armed_d   = 1'b0;
          if (balance_q >= sel_price) begin
            state_d      = ST_VEND;
            vend_valid_d = 1'b1;
            vend_item_d  = sel_idx;
          end else begin
            state_d   = ST_ERROR;
            err_d     = 1'b1;
            err_cnt_d = '0;
          end
        end else if (coin_any) begin
          if (coin_fits) begin
            balance_d     = coin_sum[BAL_W-1:0];
            coin_reject_d = coin_multi;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
`ifdef TIMEOUT_EN
        if (!activity && (balance_q != '0)) begin
          if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
            state_d = ST_CHANGE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
`endif
      end

      ST_VEND: begin
        vend_valid_d  = 1'b1;
        coin_reject_d = coin_any;
        if (vend_ready) begin
          vend_valid_d = 1'b0;
          balance_d    = vend_rem;
          state_d      = (vend_rem != '0) ? ST_CHANGE : ST_IDLE;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_any;
        if (balance_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          change_coin_d = gen_coin;
          balance_d     = change_rem;
          if (change_rem == '0) state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        coin_reject_d = coin_any;
        if (err_cnt_q == ERR_W'(ERR_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          err_d     = 1'b1;
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any pending request and credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      balance_q     <= '0;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= '0;
      change_coin_q <= '0;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      sel_armed_q   <= 1'b0;
      coin_hist_q   <= '0;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      change_coin_q <= change_coin_d;
      coin_reject_q <= coin_reject_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      sel_armed_q   <= sel_armed_d;
      coin_hist_q   <= coin_in;
    end
  end

`ifdef TIMEOUT_EN
  // Inactivity counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  assign vend_valid  = vend_valid_q;
  assign vend_item   = vend_item_q;
  assign change_coin = change_coin_q;
  assign coin_reject = coin_reject_q;
  assign err         = err_q;
  assign balance     = balance_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed self-checking bench for vending_ctrl_param (honours TIMEOUT_EN).
module tb_vending_ctrl_param;

`ifdef TIMEOUT_EN
  localparam int unsigned TO_CYC = 10;
`else
  localparam int unsigned TO_CYC = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] coin_in = 3'b000;
  logic [2:0] sel = 3'b000;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       vend_ready = 1'b0;
  logic [2:0] change_coin;
  logic       coin_reject;
  logic       err;
  logic [7:0] balance;

  int n_checks = 0;
  int n_fail   = 0;

  vending_ctrl_param #(
    .NUM_ITEMS   (3),
    .BAL_W       (8),
    .MAX_BAL     (200),
    .PRICES      ({8'd70, 8'd50, 8'd15}),
    .ERR_CYCLES  (4),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in     (coin_in),
    .sel         (sel),
    .cancel      (cancel),
    .vend_valid  (vend_valid),
    .vend_item   (vend_item),
    .vend_ready  (vend_ready),
    .change_coin (change_coin),
    .coin_reject (coin_reject),
    .err         (err),
    .balance     (balance)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cents(input logic [2:0] oh);
    case (oh)
      3'b100:  return 25;
      3'b010:  return 10;
      3'b001:  return 5;
      default: return 1000;
    endcase
  endfunction

  // Raise coin level(s) for one edge, check the result, then release.
  task automatic insert(input string tag, input logic [2:0] oh, input int exp_bal, input bit exp_rej);
    coin_in = oh;
    tick();
    check_eq({tag, "_bal"}, 32'(balance), 32'(exp_bal));
    check_eq({tag, "_rej"}, 32'(coin_reject), 32'(exp_rej));
    coin_in = 3'b000;
    tick();
  endtask

  // Request refund and total the change pulses until the controller is quiet.
  task automatic drain(input string tag, input int exp_sum, input int exp_pulses);
    int sum = 0;
    int pulses = 0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (change_coin != 3'b000) begin
        pulses++;
        sum += cents(change_coin);
      end
      if (balance == 8'd0 && change_coin == 3'b000) break;
    end
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check_eq({tag, "_bal0"}, 32'(balance), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_valid", 32'(vend_valid), 32'd0);
    check_eq("rst_coin", 32'(change_coin), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_bal", 32'(balance), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    tick();

    // 1: exact-price vend of item 1 with a stalled dispenser
    insert("t1_q", 3'b100, 25, 1'b0);
    insert("t1_d1", 3'b010, 35, 1'b0);
    insert("t1_d2", 3'b010, 45, 1'b0);
    insert("t1_n", 3'b001, 50, 1'b0);
    sel = 3'b010;
    tick();
    sel = 3'b000;
    check_eq("t1_valid", 32'(vend_valid), 32'd1);
    check_eq("t1_item", 32'(vend_item), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1_hold_valid", 32'(vend_valid), 32'd1);
      check_eq("t1_hold_item", 32'(vend_item), 32'd1);
      check_eq("t1_hold_bal", 32'(balance), 32'd50);
    end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    check_eq("t1_done_valid", 32'(vend_valid), 32'd0);
    check_eq("t1_done_bal", 32'(balance), 32'd0);
    tick();
    check_eq("t1_no_change", 32'(change_coin), 32'd0);
    check_eq("t1_idle_valid", 32'(vend_valid), 32'd0);

    // 2: insufficient credit for item 2 -> ERROR for 4 cycles, no retrigger
    insert("t2_q", 3'b100, 25, 1'b0);
    insert("t2_d", 3'b010, 35, 1'b0);
    insert("t2_n", 3'b001, 40, 1'b0);
    sel = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_err_hi", 32'(err), 32'd1);
      check_eq("t2_err_bal", 32'(balance), 32'd40);
    end
    tick();
    check_eq("t2_err_lo", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_held_err", 32'(err), 32'd0);
      check_eq("t2_held_valid", 32'(vend_valid), 32'd0);
    end
    sel = 3'b000;
    tick();
    check_eq("t2_bal_kept", 32'(balance), 32'd40);

    // 3: 85c buys item 0 (15c), 70c returned as Q,Q,D,D
    insert("t3_q", 3'b100, 65, 1'b0);
    insert("t3_d1", 3'b010, 75, 1'b0);
    insert("t3_d2", 3'b010, 85, 1'b0);
    sel = 3'b001;
    tick();
    sel = 3'b000;
    check_eq("t3_valid", 32'(vend_valid), 32'd1);
    check_eq("t3_item", 32'(vend_item), 32'd0);
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    check_eq("t3_rem", 32'(balance), 32'd70);
    check_eq("t3_valid_lo", 32'(vend_valid), 32'd0);
    tick();
    check_eq("t3_c1", 32'(change_coin), 32'b100);
    check_eq("t3_b1", 32'(balance), 32'd45);
    tick();
    check_eq("t3_c2", 32'(change_coin), 32'b100);
    check_eq("t3_b2", 32'(balance), 32'd20);
    tick();
    check_eq("t3_c3", 32'(change_coin), 32'b010);
    check_eq("t3_b3", 32'(balance), 32'd10);
    tick();
    check_eq("t3_c4", 32'(change_coin), 32'b010);
    check_eq("t3_b4", 32'(balance), 32'd0);
    tick();
    check_eq("t3_c_end", 32'(change_coin), 32'd0);

    // 4: overflow guard and simultaneous-coin priority around MAX_BAL
    for (int i = 1; i <= 7; i++) insert("t4_fill", 3'b100, 25 * i, 1'b0);
    insert("t4_d", 3'b010, 185, 1'b0);
    insert("t4_n", 3'b001, 190, 1'b0);
    insert("t4_q_ovf", 3'b100, 190, 1'b1);
    check_eq("t4_rej_pulse", 32'(coin_reject), 32'd0);
    insert("t4_n195", 3'b001, 195, 1'b0);
    insert("t4_qd", 3'b110, 195, 1'b1);
    insert("t4_n200", 3'b001, 200, 1'b0);
    insert("t4_n205", 3'b001, 200, 1'b1);
    drain("t4_drain", 200, 8);

    // 5: cancel refund, cancel at zero, reset mid-CHANGE
    insert("t5_q", 3'b100, 25, 1'b0);
    insert("t5_n", 3'b001, 30, 1'b0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    check_eq("t5_c1", 32'(change_coin), 32'b100);
    check_eq("t5_b1", 32'(balance), 32'd5);
    tick();
    check_eq("t5_c2", 32'(change_coin), 32'b001);
    check_eq("t5_b2", 32'(balance), 32'd0);
    tick();
    check_eq("t5_c_end", 32'(change_coin), 32'd0);
    cancel = 1'b1;
    tick();
    tick();
    cancel = 1'b0;
    check_eq("t5_zero_coin", 32'(change_coin), 32'd0);
    check_eq("t5_zero_bal", 32'(balance), 32'd0);
    check_eq("t5_zero_err", 32'(err), 32'd0);
    insert("t5r_q", 3'b100, 25, 1'b0);
    insert("t5r_n", 3'b001, 30, 1'b0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    check_eq("t5r_coin_pre", 32'(change_coin), 32'b100);
    rst_n = 1'b0;
    #1;
    check_eq("t5r_coin", 32'(change_coin), 32'd0);
    check_eq("t5r_bal", 32'(balance), 32'd0);
    check_eq("t5r_valid", 32'(vend_valid), 32'd0);
    check_eq("t5r_err", 32'(err), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    tick();

    // 6: inactivity behaviour with a nickel of credit
    insert("t6_n", 3'b001, 5, 1'b0);
`ifdef TIMEOUT_EN
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        tick();
        if (change_coin == 3'b001) seen = 1'b1;
      end
      check_eq("t6_timeout_pulse", 32'(seen), 32'd1);
      check_eq("t6_timeout_bal", 32'(balance), 32'd0);
    end
`else
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (change_coin != 3'b000) seen = 1'b1;
      end
      check_eq("t6_no_refund", 32'(seen), 32'd0);
      check_eq("t6_bal_held", 32'(balance), 32'd5);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
